// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle CPU memory-mapped I/O responder:
// window select bit, register-index field and per-register word indices.
package sc_io_pkg;

    // Address bit that routes a data-bus access into the I/O window.
    localparam int IO_SEL_BIT = 7;

    // Register index field inside the I/O window (word granular).
    localparam int IDX_MSB = 6;
    localparam int IDX_LSB = 2;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    typedef logic [IDX_W-1:0] reg_idx_t;

    // Word indices of the mapped registers (byte offset 0x80 + 4*index).
    localparam reg_idx_t IO_SW    = 5'd0;  // 0x80 switches, read-only
    localparam reg_idx_t IO_KEY   = 5'd1;  // 0x84 keys (1 = pressed), read-only
    localparam reg_idx_t IO_KEVT  = 5'd2;  // 0x88 sticky key-press flags, write-1-to-clear
    localparam reg_idx_t IO_LED   = 5'd3;  // 0x8C LED register
    localparam reg_idx_t IO_HEX   = 5'd4;  // 0x90 hex display value
    localparam reg_idx_t IO_TIMER = 5'd5;  // 0x94 free-running timer
    localparam reg_idx_t IO_TCMP  = 5'd6;  // 0x98 timer compare value
    localparam reg_idx_t IO_STAT  = 5'd7;  // 0x9C status, bit0 = timer match, write-1-to-clear

    // Extract the register index from a CPU byte address.
    function automatic reg_idx_t reg_idx(input logic [31:0] addr);
        return addr[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/sc_sync_ff.sv
// N-stage multi-bit synchronizer for slow asynchronous inputs (switches, keys).
// No debounce; the output follows the input N rising edges later.
module sc_sync_ff #(
    parameter int             W       = 1,
    parameter int             N       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [N];

    // Shift the raw input through the chain; reset loads the idle value everywhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/sc_io_port.sv
// Memory-mapped I/O responder on the single-cycle CPU data bus. Owns LEDs,
// the hex display value, synchronized switches/keys, sticky key-press flags
// and a prescaled timer with a sticky compare-match status bit. Reads are
// combinational so a load completes in the same cycle as its address.
module sc_io_port
    import sc_io_pkg::*;
#(
    parameter int SW_W     = 10,
    parameter int KEY_W    = 4,
    parameter int HEX_W    = 24,
    parameter int SYNC_N   = 2,
    parameter int PRESCALE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              wmem,
    output logic              io_sel,
    output logic [31:0]       rdata,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [KEY_W-1:0]  key_n,
    output logic [SW_W-1:0]   led,
    output logic [HEX_W-1:0]  hex
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    // ---------------- decode ----------------
    reg_idx_t idx;
    logic     wr_en;
    logic     wr_kevt, wr_led, wr_hex, wr_timer, wr_tcmp, wr_stat;

    assign io_sel   = addr[IO_SEL_BIT];
    assign idx      = reg_idx(addr);
    assign wr_en    = wmem & io_sel;
    assign wr_kevt  = wr_en && (idx == IO_KEVT);
    assign wr_led   = wr_en && (idx == IO_LED);
    assign wr_hex   = wr_en && (idx == IO_HEX);
    assign wr_timer = wr_en && (idx == IO_TIMER);
    assign wr_tcmp  = wr_en && (idx == IO_TCMP);
    assign wr_stat  = wr_en && (idx == IO_STAT);

    // Byte-lane bits and the address bits above the window are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:IO_SEL_BIT+1], addr[IDX_LSB-1:0]};

    // ---------------- input synchronizers ----------------
    logic [SW_W-1:0]  sw_sync;
    logic [KEY_W-1:0] key_sync_n;
    logic [KEY_W-1:0] pressed;

    sc_sync_ff #(
        .W       (SW_W),
        .N       (SYNC_N),
        .RST_VAL ('0)
    ) u_sw_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // Keys idle high, so the key chain resets to all ones (nothing pressed).
    sc_sync_ff #(
        .W       (KEY_W),
        .N       (SYNC_N),
        .RST_VAL ({KEY_W{1'b1}})
    ) u_key_sync (
        .clock (clock),
        .reset (reset),
        .d     (key_n),
        .q     (key_sync_n)
    );

    assign pressed = ~key_sync_n;

    // ---------------- key-press event flags ----------------
    logic [KEY_W-1:0] prev_pressed;
    logic [KEY_W-1:0] kevt;
    logic [KEY_W-1:0] kevt_set;
    logic [KEY_W-1:0] kevt_clr;

    assign kevt_set = pressed & ~prev_pressed;
    assign kevt_clr = wr_kevt ? wdata[KEY_W-1:0] : '0;

    // Rising edge of a synchronized press sets a sticky flag; a same-cycle clear loses to the set.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_pressed <= '0;
            kevt         <= '0;
        end else begin
            prev_pressed <= pressed;
            kevt         <= (kevt & ~kevt_clr) | kevt_set;
        end
    end

    // ---------------- LED / HEX registers ----------------
    // Software-written output registers; only the implemented low bits are stored.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
            hex <= '0;
        end else begin
            if (wr_led) led <= wdata[SW_W-1:0];
            if (wr_hex) hex <= wdata[HEX_W-1:0];
        end
    end

    // ---------------- timer ----------------
    logic [PCNT_W-1:0] pcnt;
    logic [31:0]       timer;
    logic [31:0]       tcmp;
    logic              tick;
    logic              timer_inc;
    logic              match_set;
    logic              stat_match;

    assign tick      = (pcnt == PCNT_LAST);
    // A software load of the timer takes priority over the prescaled increment.
    assign timer_inc = tick & ~wr_timer;
    // Compare the pre-increment value so the match marks the step from TCMP to TCMP+1.
    assign match_set = timer_inc && (timer == tcmp);

    // Prescale counter and timer; a timer write reloads both.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt  <= '0;
            timer <= '0;
        end else if (wr_timer) begin
            pcnt  <= '0;
            timer <= wdata;
        end else if (tick) begin
            pcnt  <= '0;
            timer <= timer + 32'd1;
        end else begin
            pcnt  <= pcnt + PCNT_W'(1);
        end
    end

    // Compare register and sticky match status; a same-cycle clear loses to the set.
    always_ff @(posedge clock) begin
        if (reset) begin
            tcmp       <= '0;
            stat_match <= 1'b0;
        end else begin
            if (wr_tcmp) tcmp <= wdata;
            stat_match <= (stat_match & ~(wr_stat & wdata[0])) | match_set;
        end
    end

    // ---------------- read mux ----------------
    // Same-cycle read data; unmapped indices and accesses outside the window return zero.
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (idx)
                IO_SW:    rdata = 32'(sw_sync);
                IO_KEY:   rdata = 32'(pressed);
                IO_KEVT:  rdata = 32'(kevt);
                IO_LED:   rdata = 32'(led);
                IO_HEX:   rdata = 32'(hex);
                IO_TIMER: rdata = timer;
                IO_TCMP:  rdata = tcmp;
                IO_STAT:  rdata = {31'd0, stat_match};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_io_port.sv
// Directed bench for sc_io_port: two instances share one CPU bus, one with
// PRESCALE=1 (timer wrap) and one with PRESCALE=3 (timer match timing).
module tb_sc_io_port;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [9:0]  sw_in;
    logic [3:0]  key_n;

    logic        io_sel1, io_sel3;
    logic [31:0] rdata1, rdata3;
    logic [9:0]  led1, led3;
    logic [23:0] hex1, hex3;

    int n_checks = 0;
    int n_errors = 0;

    sc_io_port #(.SW_W(10), .KEY_W(4), .HEX_W(24), .SYNC_N(2), .PRESCALE(1)) dut1 (
        .clock (clock), .reset (reset), .addr (addr), .wdata (wdata), .wmem (wmem),
        .io_sel (io_sel1), .rdata (rdata1), .sw_in (sw_in), .key_n (key_n),
        .led (led1), .hex (hex1)
    );

    sc_io_port #(.SW_W(10), .KEY_W(4), .HEX_W(24), .SYNC_N(2), .PRESCALE(3)) dut3 (
        .clock (clock), .reset (reset), .addr (addr), .wdata (wdata), .wmem (wmem),
        .io_sel (io_sel3), .rdata (rdata3), .sw_in (sw_in), .key_n (key_n),
        .led (led3), .hex (hex3)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wmem  = 1'b1;
        step();
        wmem  = 1'b0;
        wdata = '0;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata1, exp);
    endtask

    task automatic rd3(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata3, exp);
    endtask

    initial begin
        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        wmem  = 1'b0;
        sw_in = '0;
        key_n = 4'hF;

        // reset held for two edges
        step();
        step();
        reset = 1'b0;
        check("rst_led", 32'(led1), 32'h0);
        check("rst_hex", 32'(hex1), 32'h0);
        rd1("rst_timer", 32'h94, 32'h0);
        rd1("rst_stat",  32'h9C, 32'h0);
        rd1("rst_key",   32'h84, 32'h0);
        rd1("rst_kevt",  32'h88, 32'h0);

        // LED / HEX writes, zero fill, out-of-window and unmapped writes
        wr(32'h8C, 32'h0000_03FF);
        wr(32'h90, 32'h00AB_CDEF);
        check("led_wr", 32'(led1), 32'h3FF);
        check("hex_wr", 32'(hex1), 32'hABCDEF);
        rd1("led_rd", 32'h8C, 32'h3FF);
        rd1("hex_rd", 32'h90, 32'hABCDEF);
        wr(32'h0C, 32'h0000_0000);
        check("led_nosel", 32'(led1), 32'h3FF);
        addr = 32'h0C;
        #1;
        check("iosel_lo", 32'(io_sel1), 32'h0);
        check("rdata_nosel", rdata1, 32'h0);
        wr(32'h8C, 32'hFFFF_FC55);
        rd1("led_zfill", 32'h8C, 32'h055);
        wr(32'hA0, 32'hFFFF_FFFF);
        rd1("unmapped_rd", 32'hA0, 32'h0);
        check("led_unmapped_wr", 32'(led1), 32'h055);
        check("iosel_hi", 32'(io_sel1), 32'h1);

        // switch synchronizer latency
        sw_in = 10'h2A5;
        step();
        rd1("sw_1edge", 32'h80, 32'h0);
        step();
        rd1("sw_2edge", 32'h80, 32'h2A5);

        // key synchronizer, press event and W1C while held
        key_n = 4'b1110;
        step();
        rd1("key_1edge", 32'h84, 32'h0);
        step();
        rd1("key_2edge", 32'h84, 32'h1);
        rd1("kevt_2edge", 32'h88, 32'h0);
        step();
        rd1("kevt_set", 32'h88, 32'h1);
        wr(32'h88, 32'h1);
        rd1("kevt_w1c", 32'h88, 32'h0);
        rd1("key_held", 32'h84, 32'h1);
        key_n = 4'hF;
        step();
        step();
        rd1("key_release", 32'h84, 32'h0);
        rd1("kevt_release", 32'h88, 32'h0);

        // timer wrap with PRESCALE=1
        wr(32'h94, 32'hFFFF_FFFE);
        rd1("tmr_load", 32'h94, 32'hFFFF_FFFE);
        step();
        rd1("tmr_ffff", 32'h94, 32'hFFFF_FFFF);
        step();
        rd1("tmr_wrap", 32'h94, 32'h0);

        // match timing with PRESCALE=3: increment n happens on edge 3n after the load
        wr(32'h98, 32'h5);
        wr(32'h9C, 32'h1);
        wr(32'h94, 32'h0);
        rd3("m_stat_start", 32'h9C, 32'h0);
        for (int i = 1; i <= 17; i++) step();
        rd3("m_tmr_17", 32'h94, 32'h5);
        rd3("m_stat_17", 32'h9C, 32'h0);
        step();
        rd3("m_tmr_18", 32'h94, 32'h6);
        rd3("m_stat_18", 32'h9C, 32'h1);
        step();
        rd3("m_stat_sticky", 32'h9C, 32'h1);
        wr(32'h9C, 32'h1);
        rd3("m_stat_w1c", 32'h9C, 32'h0);

        // clear collides with a match edge: set wins
        wr(32'h98, 32'h0);
        wr(32'h94, 32'h0);
        step();
        step();
        wr(32'h9C, 32'h1);
        rd3("col_tmr", 32'h94, 32'h1);
        rd3("col_stat", 32'h9C, 32'h1);

        // reset mid-run returns everything to reset values
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_led", 32'(led1), 32'h0);
        check("mrst_hex", 32'(hex1), 32'h0);
        rd1("mrst_timer", 32'h94, 32'h0);
        rd3("mrst_stat", 32'h9C, 32'h0);
        rd1("mrst_sw", 32'h80, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
